// File: rtl/spmm_pkg.sv
// Shared definitions for the SpMM merge path sorted-insert sequencer.
// Holds the array geometry, the sequencer state type and the key extractor
// used by both the position search and the controller.
package spmm_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_ELEM = 16;
  localparam int IDX_W    = 4;
  localparam int KEY_W    = 16;
  localparam int CNT_W    = IDX_W + 1;

  typedef logic [DATA_W-1:0]                word_t;
  typedef logic [KEY_W-1:0]                 key_t;
  typedef logic [CNT_W-1:0]                 cnt_t;
  typedef logic [MAX_ELEM-1:0][DATA_W-1:0]  arr_t;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    INSERT,
    DRAIN,
    DONE
  } sic_state_t;

  // Sort key is the low KEY_W bits; upper bits are payload.
  function automatic key_t key_of(input word_t w);
    return w[KEY_W-1:0];
  endfunction

endpackage

// File: rtl/sorted_insert_ctrl_if.sv
// Bus bundle for sorted_insert_ctrl.
// Insert stream : in_valid, in_ready, in_data
// Drain stream  : out_valid, out_ready, out_data, out_last
// Control/status: flush_req, flush_done, count, full, empty, busy
// slave  = the sequencer side, master = the side feeding/draining it.
interface sorted_insert_ctrl_if;
  import spmm_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  flush_req;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  logic  out_last;
  logic  flush_done;
  cnt_t  count;
  logic  full;
  logic  empty;
  logic  busy;

  modport slave (
    input  in_valid, in_data, flush_req, out_ready,
    output in_ready, out_valid, out_data, out_last, flush_done,
           count, full, empty, busy
  );

  modport master (
    output in_valid, in_data, flush_req, out_ready,
    input  in_ready, out_valid, out_data, out_last, flush_done,
           count, full, empty, busy
  );

endinterface

// File: rtl/ins_pos_calc.sv
// Combinational insertion-position search.
// arr   : stored entries, [0..count-1] sorted ascending by key
// count : number of valid entries
// key   : key of the word being inserted
// pos   : number of valid entries whose key is <= key; inserting there
//         places equal keys after existing ones (stable order)
module ins_pos_calc
  import spmm_pkg::*;
(
  input  arr_t arr,
  input  cnt_t count,
  input  key_t key,
  output cnt_t pos
);

  logic [MAX_ELEM-1:0] le;

  always_comb begin
    le = '0;
    for (int i = 0; i < MAX_ELEM; i++) begin
      le[i] = (cnt_t'(i) < count) && (key_of(arr[i]) <= key);
    end
  end

  // Because the valid region is sorted, a popcount of the matches equals
  // the index of the first entry with a strictly larger key.
  always_comb begin
    pos = '0;
    for (int i = 0; i < MAX_ELEM; i++) begin
      pos = pos + cnt_t'(le[i]);
    end
  end

endmodule

// File: rtl/sorted_insert_ctrl.sv
// Sorted-insert sequencer: keeps MAX_ELEM words ascending by key.
// clk, rst_n : clock, asynchronous active-low reset
// bus.slave  : insert stream, drain stream, flush control and status
// An accepted word is held (IDLE), its position found (SEARCH) and the
// array shift-inserted (INSERT). A flush streams entries 0..count-1 out,
// clears the count and pulses flush_done from DONE.
module sorted_insert_ctrl
  import spmm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  sorted_insert_ctrl_if.slave  bus
);

  sic_state_t state_q, state_d;
  arr_t       arr_q, arr_shift, arr_ins;
  word_t      hold_p0, out_data_q;
  cnt_t       pos_calc, pos_p1, count_q, rd_q, rd_nxt;
  logic       full, accept, last, hs;

  assign full   = (count_q == cnt_t'(MAX_ELEM));
  // Gated by rst_n so nothing is accepted while reset is held.
  assign bus.in_ready = rst_n && (state_q == IDLE) && !full && !bus.flush_req;
  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (state_q == DRAIN) && (rd_q == count_q - cnt_t'(1));
  assign hs     = (state_q == DRAIN) && bus.out_ready;
  assign rd_nxt = rd_q + cnt_t'(1);

  ins_pos_calc u_pos (
    .arr   (arr_q),
    .count (count_q),
    .key   (key_of(hold_p0)),
    .pos   (pos_calc)
  );

  // Packed shift moves entry i-1 into slot i for every i.
  assign arr_shift = arr_q << DATA_W;

  always_comb begin
    arr_ins = arr_q;
    for (int i = 0; i < MAX_ELEM; i++) begin
      if (cnt_t'(i) == pos_p1)     arr_ins[i] = hold_p0;
      else if (cnt_t'(i) > pos_p1) arr_ins[i] = arr_shift[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req)  state_d = (count_q != '0) ? DRAIN : DONE;
        else if (accept)    state_d = SEARCH;
      end
      SEARCH:  state_d = INSERT;
      INSERT:  state_d = IDLE;
      DRAIN:   if (hs && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_q      <= '0;
      hold_p0    <= '0;
      pos_p1     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        // stage 0: capture the word; or preload the first drain word
        IDLE: begin
          if (bus.flush_req) begin
            rd_q       <= '0;
            out_data_q <= arr_q[0];
          end else if (accept) begin
            hold_p0    <= bus.in_data;
          end
        end
        // stage 1: register the insertion position
        SEARCH: pos_p1 <= pos_calc;
        // stage 2: shift-insert and grow
        INSERT: begin
          arr_q   <= arr_ins;
          count_q <= count_q + cnt_t'(1);
        end
        DRAIN: begin
          if (hs) begin
            rd_q       <= rd_nxt;
            out_data_q <= arr_q[rd_nxt[IDX_W-1:0]];
            if (last) count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = last;
  assign bus.flush_done = (state_q == DONE);
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = (count_q == '0);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sorted_insert_ctrl.sv
// Directed bench for sorted_insert_ctrl: inserts, stable ordering, full
// back-pressure, empty flush, stalled drain, and reset/priority corners.
module tb_sorted_insert_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sorted_insert_ctrl_if bus ();

  sorted_insert_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_arr [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word and wait (bounded) for it to be accepted.
  task automatic insert(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("insert_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
  endtask

  // Flush and collect n words against exp_arr. toggle selects the out_ready
  // pattern 1,0,0,1; with_valid also offers an insert alongside flush_req.
  task automatic drain(input string tag, input int n, input bit toggle, input bit with_valid);
    int k, cyc, nvalid;
    bit done_seen, prev_valid, prev_rdy, rdy;
    logic [31:0] prev_data;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    k = 0; cyc = 0; nvalid = 0;
    done_seen = 1'b0; prev_valid = 1'b0; prev_rdy = 1'b0; prev_data = '0;
    @(negedge clk);
    bus.flush_req = 1'b1;
    if (with_valid) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0002;
      #1 check({tag, "_in_ready_vs_flush"}, 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    bus.in_valid  = 1'b0;
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      rdy = toggle ? pat[cyc % 4] : 1'b1;
      cyc++;
      bus.out_ready = rdy;
      if (bus.flush_done) begin
        done_seen = 1'b1;
      end else if (bus.out_valid) begin
        nvalid++;
        if (prev_valid && !prev_rdy)
          check({tag, "_stall_data"}, bus.out_data, prev_data);
        check({tag, "_last"}, 32'(bus.out_last), 32'(k == n - 1));
        if (rdy) begin
          check({tag, "_data"}, bus.out_data, exp_arr[k]);
          k++;
        end
      end
      prev_valid = bus.out_valid;
      prev_rdy   = rdy;
      prev_data  = bus.out_data;
    end
    bus.out_ready = 1'b0;
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    check({tag, "_handshakes"}, 32'(k), 32'(n));
    if (n == 0) check({tag, "_no_valid"}, 32'(nvalid), 32'd0);
    check({tag, "_count_at_done"}, 32'(bus.count), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(bus.flush_done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush_req = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Test 1: 5,1,3 with insert timing on the first word
    insert(32'd5);
    @(negedge clk);
    check("t1_search_ready", 32'(bus.in_ready), 32'd0);
    check("t1_search_busy", 32'(bus.busy), 32'd1);
    check("t1_search_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    check("t1_insert_ready", 32'(bus.in_ready), 32'd0);
    check("t1_insert_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    check("t1_back_ready", 32'(bus.in_ready), 32'd1);
    check("t1_back_count", 32'(bus.count), 32'd1);
    insert(32'd1);
    insert(32'd3);
    wait_idle();
    check("t1_count3", 32'(bus.count), 32'd3);
    exp_arr[0] = 32'd1; exp_arr[1] = 32'd3; exp_arr[2] = 32'd5;
    drain("t1", 3, 1'b0, 1'b0);

    // Test 2: equal keys keep arrival order
    insert(32'h0001_0007);
    insert(32'h0002_0007);
    wait_idle();
    exp_arr[0] = 32'h0001_0007; exp_arr[1] = 32'h0002_0007;
    drain("t2", 2, 1'b0, 1'b0);

    // Test 3: 16 descending keys fill the array
    for (int i = 16; i >= 1; i--) insert(32'(i));
    wait_idle();
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_count", 32'(bus.count), 32'd16);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_ready_when_full", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("t3_count_after_17th", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) exp_arr[i] = 32'(i + 1);
    drain("t3", 16, 1'b0, 1'b0);

    // Test 4: flush of an empty array
    drain("t4", 0, 1'b0, 1'b0);

    // Test 5: stalled drain of 4 entries
    insert(32'd40); insert(32'd10); insert(32'd30); insert(32'd20);
    wait_idle();
    exp_arr[0] = 32'd10; exp_arr[1] = 32'd20; exp_arr[2] = 32'd30; exp_arr[3] = 32'd40;
    drain("t5", 4, 1'b1, 1'b0);

    // Test 6a: reset during INSERT
    insert(32'd8);
    @(negedge clk);
    @(negedge clk);
    check("t6a_in_insert", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6a_count", 32'(bus.count), 32'd0);
    check("t6a_ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6a_count_after", 32'(bus.count), 32'd0);
    check("t6a_busy_after", 32'(bus.busy), 32'd0);

    // Test 6b: reset mid-drain
    insert(32'd10); insert(32'd20); insert(32'd30);
    wait_idle();
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1 bus.flush_req = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6b_draining", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("t6b_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6b_count", 32'(bus.count), 32'd0);
    check("t6b_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bus.flush_done || bus.out_valid) pulses++;
      end
      check("t6b_no_done_pulse", 32'(pulses), 32'd0);
    end

    // Test 6c: flush_req and in_valid together -> flush wins
    insert(32'd50); insert(32'd60);
    wait_idle();
    exp_arr[0] = 32'd50; exp_arr[1] = 32'd60;
    drain("t6c", 2, 1'b0, 1'b1);
    check("t6c_not_inserted", 32'(bus.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sorted_insert_ctrl.md
Name: sorted_insert_ctrl

Overview:
- Sequencer that maintains a 16-entry ascending-sorted register array of 32-bit words.
- Used by the SpMM merge path to build sorted column-index/value lists.
- Accepts words over a valid/ready stream and computes each word's insertion position against the stored keys. It then applies an indexed right-shift insert: entries at or above the position move up one slot.
- On a flush request it streams the sorted contents out and clears itself.

Parameters:
- DATA_W, 32, entry width in bits.
- MAX_ELEM, 16, array depth.
- IDX_W, 4, index width; equals clog2(MAX_ELEM).
- KEY_W, 16, sort key is entry bits [KEY_W-1:0], compared unsigned; upper bits are payload and are not compared.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, insert word offered.
- in_ready, output, 1, insert word accepted when in_valid && in_ready.
- in_data, input, DATA_W, word to insert.
- flush_req, input, 1, single-cycle request to drain the array; sampled only in IDLE.
- out_valid, output, 1, drain word valid.
- out_ready, input, 1, downstream accepts drain word.
- out_data, output, DATA_W, drain word.
- out_last, output, 1, marks the final drain word.
- flush_done, output, 1, one-cycle pulse when the drain completes.
- count, output, IDX_W+1, number of stored entries (0..MAX_ELEM).
- full, output, 1, count == MAX_ELEM.
- empty, output, 1, count == 0.
- busy, output, 1, state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all array entries, count, out_data=0; out_valid, out_last, flush_done=0; empty=1; full=0; busy=0; in_ready=0 while rst_n is low. Reset mid-insert or mid-drain abandons the operation; no partial write.
- States: IDLE, SEARCH, INSERT, DRAIN, DONE.
- IDLE:
  - in_ready = !full && !flush_req (combinational).
  - Insert handshake: latch in_data into a hold register, go to SEARCH.
  - flush_req=1: go to DRAIN if count>0, else go to DONE. flush_req has priority over in_valid in the same cycle.
- SEARCH (1 cycle):
  - pos = number of valid entries i<count with key[i] <= key(hold).
  - Equal keys insert after existing entries (stable, FIFO order among equal keys).
  - Register pos; go to INSERT.
- INSERT (1 cycle):
  - new[i] = old[i] for i<pos; new[pos] = hold; new[i] = old[i-1] for pos<i<MAX_ELEM.
  - count+1; go to IDLE.
  - pos==count appends with no shift. pos==0 shifts the whole valid region.
  - Never entered when full, because in_ready gates acceptance.
- Insert timing: accept at cycle N, array and count updated at the end of cycle N+2, in_ready high again at N+3. Throughput is one insert per 3 cycles.
- DRAIN:
  - Drain pointer rd starts at 0; out_valid=1; out_data=arr[rd] (registered); out_last = (rd == count-1).
  - On out_valid && out_ready: rd+1. If out_last, clear count to 0 and go to DONE.
  - out_data and out_valid hold stable while out_ready is low.
  - Array contents need not be zeroed; entries at index >= count are don't-care.
- DONE (1 cycle): flush_done=1, out_valid=0, go to IDLE.
- Invariant: entries [0..count-1] are always non-decreasing by key.
- flush_req outside IDLE is ignored; it is not queued.
- in_ready is low in SEARCH, INSERT, DRAIN and DONE.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package spmm_pkg:
  - DATA_W, MAX_ELEM, IDX_W, KEY_W constants.
  - State enum sic_state_t {IDLE, SEARCH, INSERT, DRAIN, DONE}.
  - Function key_of(word) returning word[KEY_W-1:0].
- Sub-module ins_pos_calc:
  - Combinational.
  - Inputs: array, count, key. Output: IDX_W+1-bit pos.
  - Computes MAX_ELEM parallel <= compares masked by i<count, then a population count of the results.
- The shift-insert write stays inline in sorted_insert_ctrl.

Test Plan:
- Insert keys 5, 1, 3 (payload 0), then flush with out_ready=1 -> out_data 1, 3, 5 on consecutive cycles; out_last on 5; flush_done the following cycle; count=0.
- Insert 0x0001_0007 then 0x0002_0007 (equal key 7) -> drain order 0x0001_0007, 0x0002_0007 (stable).
- Insert 16 descending keys 16..1 -> full=1, in_ready=0 with in_valid held; a 17th word is not accepted; drain yields 1..16 with out_last on 16.
- flush_req with count=0 -> no out_valid; flush_done pulses one cycle later; state returns to IDLE.
- Drain 4 entries with out_ready toggling 1,0,0,1,... -> out_data and out_valid stable while stalled; exactly 4 handshakes; out_last only on the 4th.
- Assert rst_n low in the INSERT cycle and mid-DRAIN, and drive in_valid and flush_req high together in IDLE -> after reset count=0 and no flush_done pulse; in the simultaneous case flush is taken and in_data is not accepted.
